// File: rtl/cix32_simd_pkg.sv
// Shared types for the cix32 SIMD issue slice.
// Feature macro: CIX32_SIMD_BYPASS_EN (writeback forwarding into issue).
package cix32_simd_pkg;

    localparam int XMM_IDX_W = 3;

    typedef enum logic [4:0] {
        OP_PADDD  = 5'd0,
        OP_PSUBD  = 5'd1,
        OP_PXOR   = 5'd2,
        OP_PAND   = 5'd3,
        OP_POR    = 5'd4,
        OP_PMULLD = 5'd5,
        OP_ADDPS  = 5'd6,
        OP_MOVDQA = 5'd7
    } simd_op_e;

    typedef enum logic [2:0] {
        MODE_MMX  = 3'b000,
        MODE_SSE  = 3'b001,
        MODE_SSE2 = 3'b010,
        MODE_SSE3 = 3'b011
    } simd_mode_e;

    typedef struct packed {
        simd_op_e             op;
        logic [2:0]           mode;
        logic [XMM_IDX_W-1:0] src;
        logic [XMM_IDX_W-1:0] dst;
    } simd_uop_t;

    // Any mode with the top bit set is outside MMX..SSE3
    function automatic logic mode_illegal(input logic [2:0] m);
        return m[2];
    endfunction

endpackage

// File: rtl/cix32_simd_uop_fifo.sv
// In-order micro-op queue feeding the SIMD issue stage.
// Pointers carry one wrap bit; full/empty decided by comparing MSBs.
module cix32_simd_uop_fifo
    import cix32_simd_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push_i,
    input  logic      pop_i,
    input  simd_uop_t wdata_i,
    output simd_uop_t rdata_o,
    output logic      full_o,
    output logic      empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0] wr_q, wr_d;
    logic [AW:0] rd_q, rd_d;
    simd_uop_t   mem_q [DEPTH];

    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[AW] != rd_q[AW]) &&
                     (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign rdata_o = mem_q[rd_q[AW-1:0]];

    // Pointer advance on push/pop
    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (push_i) wr_d = wr_q + PTR_ONE;
        if (pop_i)  rd_d = rd_q + PTR_ONE;
    end

    // Pointer registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    // Entry storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (push_i) begin
            mem_q[wr_q[AW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/cix32_simd_issue.sv
// SIMD issue stage: XMM regfile, uop queue, scoreboard, execute handshake.
// Feature macro: CIX32_SIMD_BYPASS_EN (same-cycle writeback forwarding).
module cix32_simd_issue
    import cix32_simd_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int NREGS  = 8,
    parameter int DATA_W = 128
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              uop_valid,
    output logic              uop_ready,
    input  logic [4:0]        uop_op,
    input  logic [2:0]        uop_mode,
    input  logic [2:0]        uop_src,
    input  logic [2:0]        uop_dst,
    output logic              ex_valid,
    input  logic              ex_ready,
    output logic [4:0]        ex_op,
    output logic [2:0]        ex_mode,
    output logic [2:0]        ex_dst,
    output logic [DATA_W-1:0] ex_operand_a,
    output logic [DATA_W-1:0] ex_operand_b,
    input  logic              wb_valid,
    input  logic [2:0]        wb_dst,
    input  logic [DATA_W-1:0] wb_data,
    output logic              busy,
    output logic              issue_err
);

    simd_uop_t         in_uop;
    simd_uop_t         fifo_uop;
    simd_uop_t         head;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_push;
    logic              fifo_pop;
    logic              head_vld;

    logic [NREGS-1:0]  pend_q, pend_d;
    logic [NREGS-1:0]  pend_chk;
    logic [NREGS-1:0]  wb_hit;
    logic              err_q, err_d;

    logic [DATA_W-1:0] xmm_q [NREGS];
    logic [DATA_W-1:0] opa;
    logic [DATA_W-1:0] opb;

    logic              ex_valid_q, ex_valid_d;
    logic [4:0]        ex_op_q;
    logic [2:0]        ex_mode_q;
    logic [2:0]        ex_dst_q;
    logic [DATA_W-1:0] ex_a_q;
    logic [DATA_W-1:0] ex_b_q;

    logic              hazard;
    logic              slot_free;
    logic              do_issue;
    logic              do_drop;
    logic              consume;

    assign in_uop = '{op:   simd_op_e'(uop_op),
                      mode: uop_mode,
                      src:  uop_src,
                      dst:  uop_dst};

    cix32_simd_uop_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .wdata_i (in_uop),
        .rdata_o (fifo_uop),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign uop_ready = !fifo_full;

    // Head selection: an incoming uop falls through an empty queue
    always_comb begin
        head     = fifo_empty ? in_uop : fifo_uop;
        head_vld = !fifo_empty || uop_valid;
    end

    // Hazard view of the scoreboard, optionally ignoring this cycle's writeback
    always_comb begin
        wb_hit = '0;
        if (wb_valid) wb_hit[wb_dst] = 1'b1;
`ifdef CIX32_SIMD_BYPASS_EN
        pend_chk = pend_q & ~wb_hit;
`else
        pend_chk = pend_q;
`endif
    end

    // Issue / drop decision and queue control
    always_comb begin
        hazard    = pend_chk[head.src] | pend_chk[head.dst];
        slot_free = !ex_valid_q || ex_ready;
        do_drop   = head_vld && mode_illegal(head.mode);
        do_issue  = head_vld && !mode_illegal(head.mode) &&
                    slot_free && !hazard;
        consume   = do_issue || do_drop;
        fifo_pop  = consume && !fifo_empty;
        fifo_push = uop_valid && uop_ready &&
                    !(fifo_empty && consume);
    end

    // Operand read, with writeback forwarding when enabled
    always_comb begin
        opa = xmm_q[head.dst];
        opb = xmm_q[head.src];
`ifdef CIX32_SIMD_BYPASS_EN
        if (wb_valid && (wb_dst == head.dst)) opa = wb_data;
        if (wb_valid && (wb_dst == head.src)) opb = wb_data;
`endif
    end

    // Scoreboard / error next state: a set beats a same-cycle clear
    always_comb begin
        pend_d = pend_q & ~wb_hit;
        if (do_issue) pend_d[head.dst] = 1'b1;
        err_d = err_q || do_drop ||
                (wb_valid && !pend_q[wb_dst]);
        ex_valid_d = do_issue || (ex_valid_q && !ex_ready);
    end

    // Scoreboard and sticky error registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= '0;
            err_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            err_q  <= err_d;
        end
    end

    // XMM register file, written only by writeback
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) xmm_q[i] <= '0;
        end else if (wb_valid) begin
            xmm_q[wb_dst] <= wb_data;
        end
    end

    // Output register toward execute, held while stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q <= 1'b0;
            ex_op_q    <= '0;
            ex_mode_q  <= '0;
            ex_dst_q   <= '0;
            ex_a_q     <= '0;
            ex_b_q     <= '0;
        end else begin
            ex_valid_q <= ex_valid_d;
            if (do_issue) begin
                ex_op_q   <= head.op;
                ex_mode_q <= head.mode;
                ex_dst_q  <= head.dst;
                ex_a_q    <= opa;
                ex_b_q    <= opb;
            end
        end
    end

    assign ex_valid     = ex_valid_q;
    assign ex_op        = ex_op_q;
    assign ex_mode      = ex_mode_q;
    assign ex_dst       = ex_dst_q;
    assign ex_operand_a = ex_a_q;
    assign ex_operand_b = ex_b_q;
    assign issue_err    = err_q;
    assign busy         = !fifo_empty || ex_valid_q || (|pend_q);

endmodule
